// File: rtl/audio_pwm_out.sv
// Audio output stage: double-buffered sample, volume shift, PWM output and underrun fade-to-silence.
// Optional AUDIO_DITHER_EN: first-order error feedback on the bits dropped when truncating to the duty.
module audio_pwm_out #(
  parameter int PWM_BITS         = 8,
  parameter int UNDERRUN_PERIODS = 64,
  parameter int VOL_BITS         = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [15:0]         sample_in,
  input  logic                sample_valid,
  input  logic [VOL_BITS-1:0] vol_shift,
  output logic                pwm_out,
  output logic                amp_en,
  output logic                overrun,
  output logic [1:0]          state
);
  localparam int RES_BITS  = 16 - PWM_BITS;
  localparam int IDLE_BITS = $clog2(UNDERRUN_PERIODS + 1);

  localparam logic [1:0] ST_OFF  = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_FADE = 2'b10;

  localparam logic [PWM_BITS-1:0]  PWM_ONES  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0]  PWM_ZERO  = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0]  PWM_ONE   = {{(PWM_BITS-1){1'b0}}, 1'b1};
  localparam logic [IDLE_BITS-1:0] IDLE_MAX  = IDLE_BITS'(UNDERRUN_PERIODS);
  localparam logic [IDLE_BITS-1:0] IDLE_ZERO = {IDLE_BITS{1'b0}};
  localparam logic [IDLE_BITS-1:0] IDLE_ONE  = {{(IDLE_BITS-1){1'b0}}, 1'b1};

  logic [PWM_BITS-1:0]  cnt_r;
  logic [PWM_BITS-1:0]  duty_r;
  logic [PWM_BITS-1:0]  duty_next_s;
  logic [PWM_BITS-1:0]  trunc_s;
  logic [PWM_BITS-1:0]  load_duty_s;
  logic [15:0]          pending_r;
  logic [15:0]          load_val_s;
  logic                 pending_full_r;
  logic                 pe_s;
  logic                 have_s;
  logic                 load_s;
  logic                 overrun_s;
  logic                 amp_en_s;
  logic                 pwm_s;
  logic [IDLE_BITS-1:0] idle_r;
  logic [IDLE_BITS-1:0] idle_next_s;
  logic [1:0]           state_r;
  logic [1:0]           next_state_s;

  // Period-end flag and the sample a load would take (a strobe on period end bypasses the buffer).
  always_comb begin
    pe_s       = (cnt_r == PWM_ONES);
    have_s     = sample_valid | pending_full_r;
    load_val_s = sample_valid ? sample_in : pending_r;
    trunc_s    = PWM_BITS'((load_val_s >> vol_shift) >> RES_BITS);
    load_s     = pe_s & have_s & ((state_r != ST_FADE) | enable);
    overrun_s  = sample_valid & pending_full_r & ~pe_s;
  end

`ifdef AUDIO_DITHER_EN
  logic [RES_BITS-1:0] resid_r;
  logic [RES_BITS:0]   resid_sum_s;

  // Residual accumulation; its carry bumps the duty by one LSB, saturating at full scale.
  always_comb begin
    resid_sum_s = {1'b0, resid_r} + {1'b0, RES_BITS'(load_val_s >> vol_shift)};
    if (resid_sum_s[RES_BITS] && (trunc_s != PWM_ONES)) begin
      load_duty_s = trunc_s + PWM_ONE;
    end else begin
      load_duty_s = trunc_s;
    end
  end

  // Residual register, advanced on every real load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resid_r <= {RES_BITS{1'b0}};
    end else if (load_s) begin
      resid_r <= resid_sum_s[RES_BITS-1:0];
    end else begin
      resid_r <= resid_r;
    end
  end
`else
  // Plain truncation of the scaled sample.
  always_comb begin
    load_duty_s = trunc_s;
  end
`endif

  // Idle period count and duty update applied at period end.
  always_comb begin
    if (load_s) begin
      idle_next_s = IDLE_ZERO;
    end else if (idle_r == IDLE_MAX) begin
      idle_next_s = idle_r;
    end else begin
      idle_next_s = idle_r + IDLE_ONE;
    end
    if (load_s) begin
      duty_next_s = load_duty_s;
    end else if (pe_s && (state_r == ST_FADE) && (duty_r != PWM_ZERO)) begin
      duty_next_s = duty_r - PWM_ONE;
    end else begin
      duty_next_s = duty_r;
    end
  end

  // Period counter, sample buffer, active duty and idle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r          <= PWM_ZERO;
      pending_r      <= 16'h0000;
      pending_full_r <= 1'b0;
      duty_r         <= PWM_ZERO;
      idle_r         <= IDLE_ZERO;
    end else begin
      cnt_r <= cnt_r + PWM_ONE;
      if (pe_s) begin
        pending_full_r <= 1'b0;
        duty_r         <= duty_next_s;
        idle_r         <= idle_next_s;
      end else if (sample_valid) begin
        pending_r      <= sample_in;
        pending_full_r <= 1'b1;
      end else begin
        pending_full_r <= pending_full_r;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_OFF;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state; only moves at period end.
  always_comb begin
    next_state_s = state_r;
    if (pe_s) begin
      case (state_r)
        ST_OFF: begin
          if (load_s && enable) next_state_s = ST_RUN;
          else                  next_state_s = ST_OFF;
        end
        ST_RUN: begin
          if (!enable || (idle_next_s == IDLE_MAX)) next_state_s = ST_FADE;
          else                                      next_state_s = ST_RUN;
        end
        ST_FADE: begin
          if (load_s)                   next_state_s = ST_RUN;
          else if (duty_r == PWM_ZERO)  next_state_s = ST_OFF;
          else                          next_state_s = ST_FADE;
        end
        default: next_state_s = ST_OFF;
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // Output decode; amp_en follows the state being entered so it lines up with state.
  always_comb begin
    amp_en_s = (next_state_s != ST_OFF);
    pwm_s    = (state_r != ST_OFF) && (cnt_r < duty_r);
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= 1'b0;
      amp_en  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      pwm_out <= pwm_s;
      amp_en  <= amp_en_s;
      overrun <= overrun_s;
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Scoreboard bench for audio_pwm_out: a per-period reference model queues expected state, amp_en
// and high-clock count; a monitor counts pwm_out per period and checks overrun pulses.
module tb_audio_pwm_out;
  localparam int PERIOD        = 256;
  localparam int TOTAL_PERIODS = 157;
  localparam int ST_OFF = 0, ST_RUN = 1, ST_FADE = 2;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic [2:0]  vol_shift;
  logic        pwm_out;
  logic        amp_en;
  logic        overrun;
  logic [1:0]  state;

  typedef struct { int st; int amp; int hi; } exp_t;
  exp_t sb_q[$];
  int   ovr_q[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state (per-period view of the output stage).
  int m_cyc = 0, m_state = ST_OFF, m_duty = 0, m_idle = 0, m_pend = 0, m_resid = 0;
  bit m_pend_full = 1'b0;

  localparam logic [15:0] DIR_VAL [8] = '{16'h8000, 16'h8000, 16'hFFFF, 16'h00FF,
                                          16'h0080, 16'h0080, 16'h0080, 16'h0080};
  localparam int DIR_VOL [8] = '{0, 1, 0, 0, 0, 0, 0, 0};

  audio_pwm_out dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in),
    .sample_valid(sample_valid), .vol_shift(vol_shift), .pwm_out(pwm_out),
    .amp_en(amp_en), .overrun(overrun), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    int   val, scaled, d;
    bit   have;
    exp_t e;
    m_cyc++;
    if (m_cyc % PERIOD != 0) begin
      if (sample_valid) begin
        if (m_pend_full) ovr_q.push_back(m_cyc);
        m_pend      = int'(sample_in);
        m_pend_full = 1'b1;
      end
    end else begin
      have        = sample_valid || m_pend_full;
      val         = sample_valid ? int'(sample_in) : m_pend;
      m_pend_full = 1'b0;
      scaled      = val >> vol_shift;
      if (have && (m_state != ST_FADE || enable)) begin
        d = scaled / 256;
`ifdef AUDIO_DITHER_EN
        m_resid += scaled % 256;
        if (m_resid >= 256) begin
          m_resid -= 256;
          if (d < 255) d++;
        end
`endif
        m_duty = d;
        m_idle = 0;
        if (m_state == ST_OFF) begin
          if (enable) m_state = ST_RUN;
        end else if (m_state == ST_FADE) begin
          m_state = ST_RUN;
        end else if (!enable) begin
          m_state = ST_FADE;
        end
      end else begin
        if (m_idle < 64) m_idle++;
        if (m_state == ST_RUN) begin
          if (!enable || m_idle == 64) m_state = ST_FADE;
        end else if (m_state == ST_FADE) begin
          if (m_duty == 0) m_state = ST_OFF;
          else m_duty--;
        end
      end
      e.st  = m_state;
      e.amp = (m_state != ST_OFF) ? 1 : 0;
      e.hi  = (m_state != ST_OFF) ? m_duty : 0;
      sb_q.push_back(e);
    end
  endtask

  // One PWM period of stimulus: up to two strobes, the first landing on period end a third of the time.
  task automatic run_period(input logic en, input int nstb, input logic use_v0,
                            input logic [15:0] v0, input int vol);
    int p1, p2;
    p1 = ($urandom_range(0, 2) == 0) ? PERIOD - 1 : int'($urandom_range(0, PERIOD - 2));
    p2 = int'($urandom_range(0, PERIOD - 1));
    for (int c = 0; c < PERIOD; c++) begin
      @(negedge clk);
      enable       = en;
      sample_valid = (nstb >= 1 && c == p1) || (nstb >= 2 && c == p2);
      sample_in    = (use_v0 && c == p1) ? v0 : 16'($urandom);
      if (vol >= 0) vol_shift = 3'(vol);
      else if ($urandom_range(0, 199) == 0) vol_shift = 3'($urandom);
      model_step();
    end
  endtask

  task automatic monitor(input int ncyc);
    int   hi_cnt, prev_hi, j;
    bit   exp_o;
    exp_t e;
    hi_cnt  = 0;
    prev_hi = 0;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk);
      #1;
      exp_o = (ovr_q.size() > 0) && (ovr_q[0] == n);
      if (exp_o) void'(ovr_q.pop_front());
      if (exp_o || overrun) check($sformatf("overrun_c%0d", n), int'(overrun), int'(exp_o));
      hi_cnt += int'(pwm_out);
      if (n % PERIOD == 0) begin
        j = n / PERIOD;
        check($sformatf("hi_count_p%0d", j - 1), hi_cnt, prev_hi);
        hi_cnt = 0;
        if (sb_q.size() == 0) begin
          check($sformatf("scoreboard_empty_p%0d", j), 0, 1);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("state_p%0d", j), int'(state), e.st);
          check($sformatf("amp_en_p%0d", j), int'(amp_en), e.amp);
          prev_hi = e.hi;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; sample_in = 16'h0000; sample_valid = 1'b0; vol_shift = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_amp", int'(amp_en), 0);
    check("reset_state", int'(state), ST_OFF);
    check("reset_overrun", int'(overrun), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    fork
      begin
        for (int i = 0; i < 4; i++) run_period(1'b1, 0, 1'b0, 16'h0000, -1);
        for (int i = 0; i < 8; i++) run_period(1'b1, 1, 1'b1, DIR_VAL[i], DIR_VOL[i]);
        for (int i = 0; i < 24; i++) run_period(1'b1, int'($urandom_range(0, 2)), 1'b0, 16'h0000, -1);
        run_period(1'b1, 1, 1'b1, 16'h0A00, 0);
        for (int i = 0; i < 80; i++) run_period(1'b1, 0, 1'b0, 16'h0000, -1);
        for (int i = 0; i < 40; i++)
          run_period($urandom_range(0, 3) != 0, int'($urandom_range(0, 2)), 1'b0, 16'h0000, -1);
      end
      monitor(TOTAL_PERIODS * PERIOD);
    join
    check("overrun_leftover", ovr_q.size(), 0);

    // Full-scale playback, then reset mid-period must clear everything at once.
    run_period(1'b1, 1, 1'b1, 16'hFFFF, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      model_step();
    end
    check("pre_reset_state", int'(state), m_state);
    check("pre_reset_pwm", int'(pwm_out), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_pwm", int'(pwm_out), 0);
    check("async_reset_amp", int'(amp_en), 0);
    check("async_reset_state", int'(state), ST_OFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
